toy_bus_ddec_node_lsu_ack: RTL
==============================

# toy_bus_DDec_node_lsu_ack

Decoder node for the LSU ToyBusAck network: the opposite end of the two-input age-matrix arbiter node. It accepts one ToyBusAck stream, routes each beat by `tgt_id` to one of two output ports, and buffers each output in a 2-entry FIFO. Backpressure from one output never blocks traffic bound for the other output once that beat is at the input. Beats whose `tgt_id` matches no port are consumed, dropped and counted.

## Interface
Parameters:
- `OUT0_TGT_ID`, 4'd0, `tgt_id` routed to out0
- `OUT1_TGT_ID`, 4'd1, `tgt_id` routed to out1
- `FIFO_DEPTH`, 2, entries per output FIFO; legal values are 2 and 4 (power of two)

Ports:
- `clk`  in  1  clock; all logic on its rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in0_vld` in 1, `in0_rdy` out 1  input handshake
- `in0_opcode` in 1, `in0_data` in 256, `in0_sideband` in 10, `in0_src_id` in 4, `in0_tgt_id` in 4  input payload
- `out0_vld` out 1, `out0_rdy` in 1, plus `out0_opcode/data/sideband/src_id/tgt_id` out 1/256/10/4/4  port 0
- `out1_vld` out 1, `out1_rdy` in 1, plus `out1_opcode/data/sideband/src_id/tgt_id` out 1/256/10/4/4  port 1
- `err_unmapped` out 1  one-cycle pulse when an unmapped beat is dropped
- `err_cnt` out 8  saturating count of dropped beats

## Operation
- Decode: `sel0 = (in0_tgt_id == OUT0_TGT_ID)`; `sel1 = (in0_tgt_id == OUT1_TGT_ID) & ~sel0`, so out0 wins if the two IDs are equal. `unmapped = ~sel0 & ~sel1`.
- Ready: `in0_rdy = sel0 ? ~full0 : sel1 ? ~full1 : 1'b1`.
  - Depends only on `in0_tgt_id` and FIFO state; never on `in0_vld` or `outN_rdy`.
- Push: `in0_vld & in0_rdy & selN` writes the whole payload, `tgt_id` included, to FIFO N.
- Drop: `in0_vld & unmapped` is accepted and discarded.
  - `err_unmapped` goes to 1 for that cycle.
  - `err_cnt` increments and saturates at 255.
- Outputs: `outN_vld = ~emptyN`; the payload is FIFO N's head entry.
  - Pop on `outN_vld & outN_rdy`.
  - Invalid head entries are not zeroed.
- Ordering: FIFO order within each port. No ordering is guaranteed between ports.
- Each FIFO has a read pointer, a write pointer and a count (0..FIFO_DEPTH), all registered. Pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop on the same FIFO: the count is unchanged, and both pointers advance.
- Push while full is impossible because `in0_rdy` is 0. A pop in the same cycle does not open a push slot (no bypass).

## Timing
- Latency: a beat accepted in cycle N appears on `outN_vld` in cycle N+1. There is no combinational input-to-output path.
- Throughput: 1 beat/cycle when the consumer is always ready. The count then oscillates around 1, so no bubbles occur.
- Stalled port: with `outN_rdy=0`, FIFO N fills after FIFO_DEPTH pushes. After that, `in0_rdy` is 0 whenever `in0_tgt_id` targets N. The upstream master must hold its payload stable while `vld` is high and `rdy` is low.
- Reset values:
  - Counts, pointers and `err_cnt` are 0.
  - `out0_vld`, `out1_vld` and `err_unmapped` are 0.
  - Payload outputs reflect an undefined head; the bench must not check them while `vld` is 0.
- Reset mid-operation: all buffered beats are discarded. `in0_rdy` takes its reset-state value on the next cycle; for a mapped ID that value is 1, because the FIFOs are empty.
- `err_unmapped` is registered and asserts the cycle after the drop. `err_cnt` updates on the same edge.

## Structure
- Shared package `toy_bus_pkg`:
  - ToyBusAck payload struct `toy_bus_ack_t` with fields opcode[0], data[255:0], sideband[9:0], src_id[3:0], tgt_id[3:0].
  - Widths `TB_DATA_W=256`, `TB_SB_W=10`, `TB_ID_W=4`.
- Sub-module `toy_bus_CmnFifo`, parameterised by width and depth:
  - Ports: push/pop handshake, full, empty.
  - Instantiated twice, once per output.
  - The same FIFO is reused by the other decoder nodes.

## Test plan
- Reset, then 4 beats with `tgt_id` = 0, 1, 0, 1 and both `rdy` held at 1 → out0 carries beats 1 and 3, out1 carries beats 2 and 4; each appears one cycle after acceptance; `in0_rdy` stays 1 throughout.
- `out0_rdy=0`, 3 beats with `tgt_id=0` → the first 2 are accepted, then `in0_rdy=0`. Switching the held beat's `tgt_id` to 1 raises `in0_rdy` immediately and the beat goes to out1. Releasing `out0_rdy` then drains the 2 out0 beats in order.
- FIFO full, `out0_rdy=1` with a new `tgt_id=0` beat in the same cycle → the pop occurs, no push that cycle; the push lands in the next cycle.
- `tgt_id=4'd7`, `vld=1` → accepted with `in0_rdy=1`; no output `vld`; `err_unmapped` pulses; `err_cnt=1`. After 300 such beats, `err_cnt=255`.
- `OUT0_TGT_ID = OUT1_TGT_ID = 2`, beat with `tgt_id=2` → routed only to out0.
- Assert `rst` for 1 cycle with both FIFOs holding 2 entries → next cycle `out0_vld = out1_vld = 0` and `err_cnt=0`.

Source files
------------

// File: rtl/toy_bus_ddec_node_lsu_ack_pkg.sv
// Shared ToyBusAck types and helpers for the toy bus arbiter/decoder nodes.
package toy_bus_pkg;

  localparam int TB_DATA_W = 256;
  localparam int TB_SB_W   = 10;
  localparam int TB_ID_W   = 4;

  typedef struct packed {
    logic                 opcode;
    logic [TB_DATA_W-1:0] data;
    logic [TB_SB_W-1:0]   sideband;
    logic [TB_ID_W-1:0]   src_id;
    logic [TB_ID_W-1:0]   tgt_id;
  } toy_bus_ack_t;

  localparam int TB_ACK_W = $bits(toy_bus_ack_t);

  // Saturating 8-bit increment used by error counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/toy_bus_ddec_node_lsu_ack_fifo.sv
// Common synchronous FIFO shared by the toy bus decoder nodes.
// DEPTH must be a power of two so the pointers wrap naturally.
module toy_bus_CmnFifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_wptr;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign full   = (r_cnt == CW'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign dout   = r_mem[r_rptr];

  // Storage is never reset; stale entries are masked by the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/toy_bus_ddec_node_lsu_ack.sv
// LSU ToyBusAck decoder node: routes one input stream by tgt_id into two
// FIFO-buffered output ports and drops/counts beats with an unmapped tgt_id.
module toy_bus_ddec_node_lsu_ack
  import toy_bus_pkg::*;
#(
  parameter logic [3:0] OUT0_TGT_ID = 4'd0,
  parameter logic [3:0] OUT1_TGT_ID = 4'd1,
  parameter int         FIFO_DEPTH  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in0_vld,
  output logic         in0_rdy,
  input  logic         in0_opcode,
  input  logic [255:0] in0_data,
  input  logic [9:0]   in0_sideband,
  input  logic [3:0]   in0_src_id,
  input  logic [3:0]   in0_tgt_id,
  output logic         out0_vld,
  input  logic         out0_rdy,
  output logic         out0_opcode,
  output logic [255:0] out0_data,
  output logic [9:0]   out0_sideband,
  output logic [3:0]   out0_src_id,
  output logic [3:0]   out0_tgt_id,
  output logic         out1_vld,
  input  logic         out1_rdy,
  output logic         out1_opcode,
  output logic [255:0] out1_data,
  output logic [9:0]   out1_sideband,
  output logic [3:0]   out1_src_id,
  output logic [3:0]   out1_tgt_id,
  output logic         err_unmapped,
  output logic [7:0]   err_cnt
);

  logic         w_sel0;
  logic         w_sel1;
  logic         w_unmapped;
  logic         w_full0;
  logic         w_full1;
  logic         w_empty0;
  logic         w_empty1;
  logic         w_push0;
  logic         w_push1;
  toy_bus_ack_t w_in_pl;
  toy_bus_ack_t w_out0_pl;
  toy_bus_ack_t w_out1_pl;
  logic         r_err_unmapped;
  logic [7:0]   r_err_cnt;

  // out0 wins when both IDs are configured equal.
  assign w_sel0     = (in0_tgt_id == OUT0_TGT_ID);
  assign w_sel1     = (in0_tgt_id == OUT1_TGT_ID) & ~w_sel0;
  assign w_unmapped = ~w_sel0 & ~w_sel1;

  assign in0_rdy = w_sel0 ? ~w_full0 : (w_sel1 ? ~w_full1 : 1'b1);
  assign w_push0 = in0_vld & in0_rdy & w_sel0;
  assign w_push1 = in0_vld & in0_rdy & w_sel1;

  assign w_in_pl = '{opcode:   in0_opcode,
                     data:     in0_data,
                     sideband: in0_sideband,
                     src_id:   in0_src_id,
                     tgt_id:   in0_tgt_id};

  toy_bus_CmnFifo #(.W(TB_ACK_W), .DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push0),
    .pop   (out0_vld & out0_rdy),
    .din   (w_in_pl),
    .dout  (w_out0_pl),
    .full  (w_full0),
    .empty (w_empty0)
  );

  toy_bus_CmnFifo #(.W(TB_ACK_W), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push1),
    .pop   (out1_vld & out1_rdy),
    .din   (w_in_pl),
    .dout  (w_out1_pl),
    .full  (w_full1),
    .empty (w_empty1)
  );

  assign out0_vld      = ~w_empty0;
  assign out0_opcode   = w_out0_pl.opcode;
  assign out0_data     = w_out0_pl.data;
  assign out0_sideband = w_out0_pl.sideband;
  assign out0_src_id   = w_out0_pl.src_id;
  assign out0_tgt_id   = w_out0_pl.tgt_id;

  assign out1_vld      = ~w_empty1;
  assign out1_opcode   = w_out1_pl.opcode;
  assign out1_data     = w_out1_pl.data;
  assign out1_sideband = w_out1_pl.sideband;
  assign out1_src_id   = w_out1_pl.src_id;
  assign out1_tgt_id   = w_out1_pl.tgt_id;

  // Drop reporting is registered: pulse and count land one cycle after the drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_unmapped <= 1'b0;
      r_err_cnt      <= 8'd0;
    end else begin
      r_err_unmapped <= in0_vld & w_unmapped;
      if (in0_vld & w_unmapped) begin
        r_err_cnt <= sat_inc8(r_err_cnt);
      end
    end
  end

  assign err_unmapped = r_err_unmapped;
  assign err_cnt      = r_err_cnt;

endmodule
